multdiv_unit: RTL

Multicycle signed multiply/divide unit used by the execute stage for mul/div instructions. Takes a one-cycle start pulse with two 32-bit operands. Iterates internally and returns a 32-bit result with an exception flag and a one-cycle ready pulse. The execute stage stalls on busy; the result then feeds the execute/memory latch, which supplies the memory stage's operation/address input.

---
 rtl/multdiv_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply/divide unit for the execute stage (32-iteration shift-add / restoring divide).
// Define MULTDIV_BOOTH_RADIX4_EN to run multiplies as 16-iteration radix-4 modified Booth.
module multdiv_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_operandA,
    input  logic [DATA_WIDTH-1:0] data_operandB,
    input  logic                  ctrl_MULT,
    input  logic                  ctrl_DIV,
    output logic [DATA_WIDTH-1:0] data_result,
    output logic                  data_exception,
    output logic                  data_resultRDY,
    output logic                  busy
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W + 1);
`ifdef MULTDIV_BOOTH_RADIX4_EN
    localparam int unsigned MULT_STEPS = W / 2;
`else
    localparam int unsigned MULT_STEPS = W;
`endif
    localparam int unsigned DIV_STEPS = W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]     state, state_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic [2*W-1:0] prod, prod_nxt;       // mult: {acc_hi, multiplier}; div: {remainder, quotient}
    logic [W-1:0]   mcand, mcand_nxt;     // multiplicand or divisor magnitude
    logic           neg, neg_nxt;
    logic           div_zero, div_zero_nxt;
    logic           div_ovf, div_ovf_nxt;
    logic [W-1:0]   result_nxt;
    logic           exception_nxt;
    logic           rdy_nxt;
    logic           busy_nxt;
`ifdef MULTDIV_BOOTH_RADIX4_EN
    logic [2*W-1:0] booth_mc, booth_mc_nxt;
    logic [W:0]     booth_mq, booth_mq_nxt;
    logic [2*W-1:0] booth_pp;
`else
    logic [W:0]     mul_sum;
`endif

    logic           start;
    logic [W-1:0]   mag_a;
    logic [W-1:0]   mag_b;
    logic [W:0]     div_shift;
    logic           div_fits;
    logic [2*W-1:0] prod_fin;
    logic [W-1:0]   quo_fin;
    logic           mult_ovf;

    // Magnitudes: the most-negative value maps to 2^(W-1), which is exact as unsigned W bits.
    assign start = ctrl_MULT | ctrl_DIV;
    assign mag_a = data_operandA[W-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[W-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            prod           <= '0;
            mcand          <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef MULTDIV_BOOTH_RADIX4_EN
            booth_mc       <= '0;
            booth_mq       <= '0;
`endif
        end else begin
            state          <= state_nxt;
            count          <= count_nxt;
            prod           <= prod_nxt;
            mcand          <= mcand_nxt;
            neg            <= neg_nxt;
            div_zero       <= div_zero_nxt;
            div_ovf        <= div_ovf_nxt;
            data_result    <= result_nxt;
            data_exception <= exception_nxt;
            data_resultRDY <= rdy_nxt;
            busy           <= busy_nxt;
`ifdef MULTDIV_BOOTH_RADIX4_EN
            booth_mc       <= booth_mc_nxt;
            booth_mq       <= booth_mq_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        prod_nxt      = prod;
        mcand_nxt     = mcand;
        neg_nxt       = neg;
        div_zero_nxt  = div_zero;
        div_ovf_nxt   = div_ovf;
        result_nxt    = data_result;
        exception_nxt = data_exception;
        rdy_nxt       = 1'b0;
        busy_nxt      = busy;
`ifdef MULTDIV_BOOTH_RADIX4_EN
        booth_mc_nxt  = booth_mc;
        booth_mq_nxt  = booth_mq;
        booth_pp      = '0;
        case (booth_mq[2:0])
            3'b001, 3'b010: booth_pp = booth_mc;
            3'b011:         booth_pp = {booth_mc[2*W-2:0], 1'b0};
            3'b100:         booth_pp = -{booth_mc[2*W-2:0], 1'b0};
            3'b101, 3'b110: booth_pp = -booth_mc;
            default:        booth_pp = '0;
        endcase
        prod_fin      = prod;
`else
        mul_sum       = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_fin      = neg ? -prod : prod;
`endif
        div_shift     = {prod[2*W-1:W], prod[W-1]};
        div_fits      = div_shift >= {1'b0, mcand};
        quo_fin       = neg ? -prod[W-1:0] : prod[W-1:0];
        mult_ovf      = !((&prod_fin[2*W-1:W-1]) || !(|prod_fin[2*W-1:W-1]));

        // A start pulse is honoured in every state, aborting any operation in flight.
        if (start) begin
            state_nxt    = ctrl_MULT ? MULT : DIV;
            count_nxt    = '0;
            busy_nxt     = 1'b1;
            neg_nxt      = data_operandA[W-1] ^ data_operandB[W-1];
            div_zero_nxt = (data_operandB == '0);
            div_ovf_nxt  = (data_operandA == MOST_NEG) && (data_operandB == '1);
            if (ctrl_MULT) begin
`ifdef MULTDIV_BOOTH_RADIX4_EN
                prod_nxt     = '0;
                booth_mc_nxt = {{W{data_operandA[W-1]}}, data_operandA};
                booth_mq_nxt = {data_operandB, 1'b0};
`else
                prod_nxt     = {{W{1'b0}}, mag_b};
                mcand_nxt    = mag_a;
`endif
            end else begin
                prod_nxt  = {{W{1'b0}}, mag_a};
                mcand_nxt = mag_b;
            end
        end else begin
            case (state)
                MULT: begin
                    if (count == CW'(MULT_STEPS)) begin
                        result_nxt    = prod_fin[W-1:0];
                        exception_nxt = mult_ovf;
                        rdy_nxt       = 1'b1;
                        state_nxt     = DONE;
                    end else begin
`ifdef MULTDIV_BOOTH_RADIX4_EN
                        prod_nxt     = prod + booth_pp;
                        booth_mc_nxt = {booth_mc[2*W-3:0], 2'b00};
                        booth_mq_nxt = {2'b00, booth_mq[W:2]};
`else
                        prod_nxt     = {mul_sum, prod[W-1:1]};
`endif
                        count_nxt    = count + CW'(1);
                    end
                end
                DIV: begin
                    if (count == CW'(DIV_STEPS)) begin
                        result_nxt    = div_zero ? '0 : quo_fin;
                        exception_nxt = div_zero | div_ovf;
                        rdy_nxt       = 1'b1;
                        state_nxt     = DONE;
                    end else begin
                        prod_nxt[2*W-1:W] = div_fits ? W'(div_shift - {1'b0, mcand})
                                                     : div_shift[W-1:0];
                        prod_nxt[W-1:0]   = {prod[W-2:0], div_fits};
                        count_nxt         = count + CW'(1);
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule
